// File: rtl/programmable_clock_divider.sv
// Programmable clock divider with glitch-free run-time ratio changes.
//
// The output period is split into a high phase of ceil(N/2) source cycles and a
// low phase of floor(N/2) source cycles, where N is the active ratio. A new
// ratio is captured through a valid/ready handshake and only takes effect at a
// period boundary (the last low cycle, or any idle cycle), so no runt phases
// are ever produced. N=0 stops the output; N=1 is clamped to 2.
//
// Ports:
//   clock          source clock, all logic on its rising edge
//   resetn         asynchronous active-low reset
//   enable         output enable, sampled at period boundaries only
//   divider_value  requested division ratio
//   divider_valid  request valid
//   divider_ready  request can be accepted (no pending ratio held)
//   clock_out      divided clock, registered
//   period_start   one-cycle pulse in the first high cycle of each period
//   active_divider ratio currently in effect
module programmable_clock_divider #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned RESET_DIVIDER = 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             enable,
  input  logic [WIDTH-1:0] divider_value,
  input  logic             divider_valid,
  output logic             divider_ready,
  output logic             clock_out,
  output logic             period_start,
  output logic [WIDTH-1:0] active_divider
);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  // A ratio of 1 cannot be split into two non-empty phases; run it as 2.
  function automatic logic [WIDTH-1:0] clamp_ratio(input logic [WIDTH-1:0] v);
    return (v == WIDTH'(1)) ? WIDTH'(2) : v;
  endfunction

  localparam logic [WIDTH-1:0] ResetRatio = clamp_ratio(WIDTH'(RESET_DIVIDER));

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             clock_out_q, clock_out_d;
  logic             period_start_q, period_start_d;

  logic [WIDTH-1:0] high_len, low_len, next_ratio;
  logic             accept, boundary;

  // ceil(N/2) and floor(N/2) without a wider adder.
  assign low_len  = {1'b0, active_q[WIDTH-1:1]};
  assign high_len = low_len + WIDTH'(active_q[0]);

  assign accept   = divider_valid && !pend_valid_q;
  assign boundary = (state_q == StIdle) || ((state_q == StLow) && (cnt_q == low_len));

  // A request arriving on a boundary cycle bypasses the pending slot.
  assign next_ratio = accept       ? clamp_ratio(divider_value) :
                      pend_valid_q ? pend_q : active_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    active_d       = active_q;
    pend_d         = pend_q;
    pend_valid_d   = pend_valid_q;
    clock_out_d    = 1'b0;
    period_start_d = 1'b0;

    if (boundary) begin
      active_d     = next_ratio;
      pend_valid_d = 1'b0;
      if (enable && (next_ratio != '0)) begin
        state_d        = StHigh;
        cnt_d          = WIDTH'(1);
        period_start_d = 1'b1;
      end else begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    end else begin
      if (accept) begin
        pend_valid_d = 1'b1;
        pend_d       = clamp_ratio(divider_value);
      end
      unique case (state_q)
        StHigh: begin
          if (cnt_q == high_len) begin
            state_d = StLow;
            cnt_d   = WIDTH'(1);
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
        StLow:   cnt_d = cnt_q + WIDTH'(1);
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end

    clock_out_d = (state_d == StHigh);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      active_q       <= ResetRatio;
      pend_q         <= '0;
      pend_valid_q   <= 1'b0;
      clock_out_q    <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      active_q       <= active_d;
      pend_q         <= pend_d;
      pend_valid_q   <= pend_valid_d;
      clock_out_q    <= clock_out_d;
      period_start_q <= period_start_d;
    end
  end

  assign divider_ready  = !pend_valid_q;
  assign clock_out      = clock_out_q;
  assign period_start   = period_start_q;
  assign active_divider = active_q;

endmodule

// File: tb/tb_programmable_clock_divider.sv
// Self-checking bench for programmable_clock_divider: directed scenarios then
// randomized requests, compared every cycle against a period/position model.
module tb_programmable_clock_divider;

  localparam int unsigned WIDTH         = 8;
  localparam int unsigned RESET_DIVIDER = 2;

  logic             clock = 1'b0;
  logic             resetn;
  logic             enable;
  logic [WIDTH-1:0] divider_value;
  logic             divider_valid;
  logic             divider_ready;
  logic             clock_out;
  logic             period_start;
  logic [WIDTH-1:0] active_divider;

  int checks = 0;
  int errors = 0;

  programmable_clock_divider #(
    .WIDTH        (WIDTH),
    .RESET_DIVIDER(RESET_DIVIDER)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .enable        (enable),
    .divider_value (divider_value),
    .divider_valid (divider_valid),
    .divider_ready (divider_ready),
    .clock_out     (clock_out),
    .period_start  (period_start),
    .active_divider(active_divider)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the output is a sequence of periods; within a period the
  // position runs 0..n-1 and the output is high for the first ceil(n/2) positions.
  int  m_active;
  bit  m_pend_valid;
  int  m_pend;
  bit  m_running;
  int  m_pos;
  int  m_per_n;

  function automatic int clamp(input int v);
    return (v == 1) ? 2 : v;
  endfunction

  function automatic bit m_out();
    return m_running && (m_pos < (m_per_n + 1) / 2);
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_active     = clamp(RESET_DIVIDER);
      m_pend_valid = 0;
      m_pend       = 0;
      m_running    = 0;
      m_pos        = 0;
      m_per_n      = 0;
    end else begin
      bit boundary;
      bit accept;
      int n;
      boundary = !m_running || (m_pos == m_per_n - 1);
      accept   = divider_valid && !m_pend_valid;
      if (boundary) begin
        n = accept ? clamp(int'(divider_value)) : (m_pend_valid ? m_pend : m_active);
        m_active     = n;
        m_pend_valid = 0;
        if (enable && n != 0) begin
          m_running = 1;
          m_pos     = 0;
          m_per_n   = n;
        end else begin
          m_running = 0;
        end
      end else begin
        m_pos++;
        if (accept) begin
          m_pend_valid = 1;
          m_pend       = clamp(int'(divider_value));
        end
      end
    end
  end

  task automatic compare();
    check_eq("clock_out", clock_out, m_out());
    check_eq("period_start", period_start, m_running && m_pos == 0);
    check_eq("divider_ready", divider_ready, !m_pend_valid);
    check_eq("active_divider", active_divider, m_active);
  endtask

  // Check state left by the previous edge, then drive the next cycle's inputs.
  task automatic cycle(input logic en, input logic vld, input int unsigned val);
    @(negedge clock);
    compare();
    enable        = en;
    divider_valid = vld;
    divider_value = WIDTH'(val);
  endtask

  initial begin
    int budget;
    resetn        = 1'b0;
    enable        = 1'b1;
    divider_valid = 1'b0;
    divider_value = '0;
    repeat (2) @(negedge clock);
    check_eq("rst_clock_out", clock_out, 0);
    check_eq("rst_ready", divider_ready, 1);
    check_eq("rst_active", active_divider, RESET_DIVIDER);
    resetn = 1'b1;

    // Free-running at the reset ratio; first rise on the first edge.
    repeat (6) cycle(1, 0, 0);
    // Request 5 mid-period, then let it take hold.
    cycle(1, 1, 5);
    repeat (12) cycle(1, 0, 0);
    // Request 4 somewhere, possibly on a boundary; then 3.
    cycle(1, 1, 4);
    repeat (10) cycle(1, 0, 0);
    cycle(1, 1, 3);
    repeat (8) cycle(1, 0, 0);
    // Drop enable mid-period, idle, reassert.
    repeat (2) cycle(0, 0, 0);
    repeat (6) cycle(0, 0, 0);
    repeat (6) cycle(1, 0, 0);
    // Stop with 0 then restart with 1 (clamped to 2).
    cycle(1, 1, 0);
    repeat (8) cycle(1, 0, 0);
    cycle(1, 1, 1);
    repeat (8) cycle(1, 0, 0);

    // Reset while high with N=6.
    cycle(1, 1, 6);
    budget = 0;
    while (!(m_active == 6 && m_out()) && budget < 100) begin
      cycle(1, 0, 0);
      budget++;
    end
    check_eq("reach_high_n6", budget < 100, 1);
    #2 resetn = 1'b0;
    #1;
    check_eq("async_clock_out", clock_out, 0);
    check_eq("async_active", active_divider, RESET_DIVIDER);
    check_eq("async_ready", divider_ready, 1);
    check_eq("async_period_start", period_start, 0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (6) cycle(1, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int unsigned val;
      logic en;
      logic vld;
      val = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 9);
      en  = ($urandom_range(0, 7) != 0);
      vld = ($urandom_range(0, 3) == 0);
      cycle(en, vld, val);
    end
    cycle(1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/programmable_clock_divider.md
Name: programmable_clock_divider

Overview:
- Generates a derived output clock from a single source clock; the division ratio is reprogrammable at run time.
- Ratio changes are glitch-free and take effect only on output period boundaries, so no runt high or low phase is ever produced.
- Produces the clean divided clocks that feed the switchover and clock-selection blocks downstream.
- Output is fully registered; no combinational path from the source clock to clock_out.

Parameters:
- WIDTH, 8, width of the divider ratio.
- RESET_DIVIDER, 2, ratio loaded at reset; 0 means the output is stopped after reset.

Ports:
- clock  input  1  source clock; all logic is on its rising edge.
- resetn  input  1  asynchronous active-low reset.
- enable  input  1  output clock enable; takes effect only at period boundaries.
- divider_value  input  WIDTH  requested division ratio.
- divider_valid  input  1  request valid.
- divider_ready  output  1  request can be accepted; transfer occurs when valid and ready are both high.
- clock_out  output  1  divided clock, registered.
- period_start  output  1  one-cycle pulse, high during the first cycle of each output period (same cycle clock_out first reads 1).
- active_divider  output  WIDTH  ratio currently in effect.

Behaviour:
- Reset values (asynchronous):
  - clock_out=0, period_start=0, divider_ready=1.
  - active_divider=RESET_DIVIDER, pending ratio cleared, counter=0, state=IDLE.
- Ratio rules:
  - N = active_divider.
  - N=0: output stopped.
  - N=1: treated as 2 (clamped); active_divider reports 2.
  - Legal range 2..2^WIDTH-1.
- Phase lengths: high = ceil(N/2) cycles, low = floor(N/2) cycles. Examples: N=2 is 1/1, N=3 is 2/1, N=4 is 2/2, N=5 is 3/2.
- State machine (states IDLE, HIGH, LOW):
  - IDLE: clock_out=0.
    - If enable=1 and N≠0, go to HIGH on the next edge: clock_out=1, period_start=1, counter=1.
  - HIGH: counter increments each cycle. After ceil(N/2) cycles high, go to LOW with clock_out=0.
  - LOW: after floor(N/2) cycles low, the boundary is reached.
    - If enable=1 and N≠0, go to HIGH and pulse period_start (back-to-back periods, no extra idle cycle).
    - Otherwise go to IDLE.
- Period boundary definitions:
  - The last LOW cycle is a boundary.
  - Every IDLE cycle is a boundary.
- Latency: with resetn released, enable=1 and RESET_DIVIDER=2, clock_out rises on the first clock edge after reset release.
- Ratio update handshake:
  - divider_ready = no pending ratio held.
  - An accepted value is stored as pending; divider_ready drops the next cycle.
  - The pending value is loaded into active_divider at the next boundary edge. The new period uses the new ratio, pending is cleared, and divider_ready rises.
  - A value accepted on a boundary cycle bypasses pending and applies at that same edge; divider_ready stays 1.
  - While pending is held, divider_valid is ignored.
  - Requesting the same value as active is legal and behaves identically.
- Enable:
  - Deassertion mid-period does not truncate the period; the current period completes, then the block idles low.
  - Reassertion while IDLE rises clock_out on the next edge.
- Stop and start:
  - Loading N=0 at a boundary sends the block to IDLE after the current period completes.
  - Loading nonzero N while IDLE starts on the edge it is applied.
- Reset mid-period: clock_out drops to 0 immediately (asynchronously). A truncated high phase is acceptable only at reset.
- Counter width: WIDTH bits. It never exceeds N-1, so there is no wrap-around.

Test Plan:
- Reset with RESET_DIVIDER=2, enable=1, release resetn -> clock_out toggles every cycle; first rise on first edge; period_start high every 2nd cycle.
- Request N=5 mid-HIGH of an N=2 period -> current 1/1 period completes; next period is 3 high / 2 low; divider_ready low until the boundary; active_divider=5 from that edge.
- Request N=4 on the exact boundary cycle -> applied same edge; divider_ready never drops; next period 2/2.
- With N=3, drop enable on the second HIGH cycle -> remaining high and low cycles still complete (2/1), then clock_out stays 0; reassert enable -> rise on the next edge with period_start=1.
- Request N=0 then N=1 -> output stops after the current period; applying N=1 restarts with 1/1 and active_divider=2; no high or low phase shorter than 1 cycle anywhere.
- Assert resetn=0 during HIGH with N=6 -> clock_out=0 immediately, active_divider=RESET_DIVIDER, divider_ready=1; on release, normal start.
